// File: rtl/evm_result_reader.sv
// evm_result_reader: scans the four candidate tallies out of a votingMachine by
// switching it to display mode, pressing each candidate button in turn and
// capturing the led value. It then publishes the counts, the winner and a tie flag.
module evm_result_reader #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] led,
    output logic       mode,
    output logic       button1,
    output logic       button2,
    output logic       button3,
    output logic       button4,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic [7:0] count1,
    output logic [7:0] count2,
    output logic [7:0] count3,
    output logic [7:0] count4,
    output logic [1:0] winner,
    output logic       tie
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PH_W  = 8;
    localparam int unsigned NCAND = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic [PH_W-1:0] HOLD_LOAD = PH_W'(HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0] GAP_LOAD  = PH_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCAND - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PRESS,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [CNT_W-1:0]    shadow_q [NCAND];

    logic                mode_q, mode_d;
    logic [NCAND-1:0]    buttons_q, buttons_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    counts_q [NCAND];
    logic [CNT_W-1:0]    counts_d [NCAND];
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic                tie_q, tie_d;

    logic [CNT_W-1:0]    best_val;
    logic [IDX_W-1:0]    best_idx;
    logic                best_tie;

    // State register with the candidate index and the per-phase down-counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    // Next-state logic: the phase counter reloads on every PRESS/GAP entry
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_PRESS;
                idx_d   = '0;
                phase_d = HOLD_LOAD;
            end
            S_PRESS: begin
                if (phase_q == '0) begin
                    state_d = S_GAP;
                    phase_d = GAP_LOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            S_GAP: begin
                if (phase_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PRESS;
                        idx_d   = idx_q + IDX_W'(1);
                        phase_d = HOLD_LOAD;
                    end
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture led on the edge that ends the final cycle of each press
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NCAND; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (state_q == S_PRESS && phase_q == '0) begin
            shadow_q[idx_q] <= led;
        end
    end

    // Winner search: strict maximum, the lowest index keeps equal maxima
    always_comb begin
        best_val = shadow_q[0];
        best_idx = '0;
        best_tie = 1'b0;
        for (int i = 1; i < NCAND; i++) begin
            if (shadow_q[i] > best_val) begin
                best_val = shadow_q[i];
                best_idx = IDX_W'(i);
                best_tie = 1'b0;
            end else if (shadow_q[i] == best_val) begin
                best_tie = 1'b1;
            end
        end
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        mode_d    = 1'b0;
        buttons_d = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        valid_d   = valid_q;
        counts_d  = counts_q;
        winner_d  = winner_q;
        tie_d     = tie_q;
        unique case (state_d)
            S_SETUP, S_GAP: begin
                mode_d = 1'b1;
                busy_d = 1'b1;
            end
            S_PRESS: begin
                mode_d    = 1'b1;
                busy_d    = 1'b1;
                buttons_d = NCAND'(4'b0001 << idx_d);
            end
            S_DONE: begin
                done_d   = 1'b1;
                valid_d  = 1'b1;
                counts_d = shadow_q;
                winner_d = best_idx;
                tie_d    = best_tie;
            end
            default: begin
            end
        endcase
        if (state_q == S_IDLE && state_d == S_SETUP) begin
            valid_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q    <= 1'b0;
            buttons_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            winner_q  <= '0;
            tie_q     <= 1'b0;
            for (int i = 0; i < NCAND; i++) begin
                counts_q[i] <= '0;
            end
        end else begin
            mode_q    <= mode_d;
            buttons_q <= buttons_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            winner_q  <= winner_d;
            tie_q     <= tie_d;
            counts_q  <= counts_d;
        end
    end

    assign mode         = mode_q;
    assign button1      = buttons_q[0];
    assign button2      = buttons_q[1];
    assign button3      = buttons_q[2];
    assign button4      = buttons_q[3];
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = valid_q;
    assign count1       = counts_q[0];
    assign count2       = counts_q[1];
    assign count3       = counts_q[2];
    assign count4       = counts_q[3];
    assign winner       = winner_q;
    assign tie          = tie_q;

endmodule

// File: tb/tb_evm_result_reader.sv
// Bench for evm_result_reader: two readers (default timing and a short 2/1 timing)
// each drive their own votingMachine model; a timeline model predicts every output.
module tb_evm_result_reader;

    localparam int NI    = 2;
    localparam int HOLD0 = 16;
    localparam int GAP0  = 4;
    localparam int HOLD1 = 2;
    localparam int GAP1  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       vm_clr;
    logic [3:0] vote_btn;

    logic [NI-1:0] mode_w, busy_w, done_w, rv_w, tie_w;
    logic [3:0]    btn_w  [NI];
    logic [7:0]    cnt_w  [NI][4];
    logic [1:0]    win_w  [NI];
    logic [7:0]    led_q  [NI];
    logic [7:0]    tally  [NI][4];
    logic [3:0]    prev_in[NI];

    int nvec = 0;
    int nerr = 0;

    evm_result_reader #(.HOLD_CYCLES(HOLD0), .GAP_CYCLES(GAP0)) u_dut (
        .clock(clk), .reset(rst), .start(start), .led(led_q[0]),
        .mode(mode_w[0]), .button1(btn_w[0][0]), .button2(btn_w[0][1]),
        .button3(btn_w[0][2]), .button4(btn_w[0][3]), .busy(busy_w[0]),
        .done(done_w[0]), .result_valid(rv_w[0]),
        .count1(cnt_w[0][0]), .count2(cnt_w[0][1]), .count3(cnt_w[0][2]), .count4(cnt_w[0][3]),
        .winner(win_w[0]), .tie(tie_w[0])
    );

    evm_result_reader #(.HOLD_CYCLES(HOLD1), .GAP_CYCLES(GAP1)) u_dut_short (
        .clock(clk), .reset(rst), .start(start), .led(led_q[1]),
        .mode(mode_w[1]), .button1(btn_w[1][0]), .button2(btn_w[1][1]),
        .button3(btn_w[1][2]), .button4(btn_w[1][3]), .busy(busy_w[1]),
        .done(done_w[1]), .result_valid(rv_w[1]),
        .count1(cnt_w[1][0]), .count2(cnt_w[1][1]), .count3(cnt_w[1][2]), .count4(cnt_w[1][3]),
        .winner(win_w[1]), .tie(tie_w[1])
    );

    function automatic int hold_of(input int i);
        return (i == 0) ? HOLD0 : HOLD1;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? GAP0 : GAP1;
    endfunction

    function automatic int scan_len(input int i);
        return 1 + 4 * (hold_of(i) + gap_of(i));
    endfunction

    function automatic logic [7:0] led_sel(input int i);
        logic [7:0] v;
        v = 8'd0;
        for (int k = 0; k < 4; k++) begin
            if (btn_w[i][k]) v = tally[i][k];
        end
        return v;
    endfunction

    // votingMachine model: counts rising button edges in mode 0, shows the pressed tally in mode 1
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (vm_clr)
                    tally[i][k] <= 8'd0;
                else if (!mode_w[i] && (vote_btn[k] | btn_w[i][k]) && !prev_in[i][k])
                    tally[i][k] <= tally[i][k] + 8'd1;
            end
            prev_in[i] <= vote_btn | btn_w[i];
            led_q[i]   <= mode_w[i] ? led_sel(i) : 8'd0;
        end
    end

    // Reference model: position within the scan timeline, -1 when idle
    int         pos [NI];
    int         acc [NI];
    logic [7:0] ec  [NI][4];
    logic [1:0] ew  [NI];
    logic       et  [NI];
    logic       erv [NI];
    int         cyc = 0;
    bit         chk_en = 1'b0;
    int         m_mx, m_n, m_w;

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                pos[i] = -1;
                erv[i] = 1'b0;
                ew[i]  = 2'd0;
                et[i]  = 1'b0;
                for (int k = 0; k < 4; k++) ec[i][k] = 8'd0;
                chk_en = 1'b1;
            end else if (pos[i] < 0) begin
                if (start) begin
                    pos[i] = 0;
                    erv[i] = 1'b0;
                    acc[i] = cyc;
                end
            end else if (pos[i] < scan_len(i)) begin
                pos[i] = pos[i] + 1;
                if (pos[i] == scan_len(i)) begin
                    for (int k = 0; k < 4; k++) ec[i][k] = tally[i][k];
                    m_mx = 0;
                    for (int k = 0; k < 4; k++) if (int'(ec[i][k]) > m_mx) m_mx = int'(ec[i][k]);
                    m_n = 0;
                    m_w = -1;
                    for (int k = 0; k < 4; k++) begin
                        if (int'(ec[i][k]) == m_mx) begin
                            m_n = m_n + 1;
                            if (m_w < 0) m_w = k;
                        end
                    end
                    ew[i]  = 2'(m_w);
                    et[i]  = (m_n > 1);
                    erv[i] = 1'b1;
                end
            end else begin
                pos[i] = -1;
            end
        end
    end

    function automatic logic [42:0] exp_vec(input int i);
        int t, per, k, r;
        logic m, b, d;
        logic [3:0] bt;
        t = pos[i];
        per = hold_of(i) + gap_of(i);
        m = 1'b0; b = 1'b0; d = 1'b0; bt = 4'd0;
        if (t >= 0 && t < scan_len(i)) begin
            m = 1'b1;
            b = 1'b1;
            if (t >= 1) begin
                k = (t - 1) / per;
                r = (t - 1) % per;
                if (r < hold_of(i)) bt = 4'(1 << k);
            end
        end else if (t == scan_len(i)) begin
            d = 1'b1;
        end
        return {m, bt, b, d, erv[i], ec[i][0], ec[i][1], ec[i][2], ec[i][3], ew[i], et[i]};
    endfunction

    function automatic logic [42:0] dut_vec(input int i);
        return {mode_w[i], btn_w[i], busy_w[i], done_w[i], rv_w[i],
                cnt_w[i][0], cnt_w[i][1], cnt_w[i][2], cnt_w[i][3], win_w[i], tie_w[i]};
    endfunction

    function automatic logic [31:0] counts_of(input int i);
        return {cnt_w[i][0], cnt_w[i][1], cnt_w[i][2], cnt_w[i][3]};
    endfunction

    // Per-cycle compare against the model plus button/mode invariants on the short reader
    int         done_cnt [NI];
    int         last_lat [NI];
    logic [3:0] prev_b1 = 4'd0;
    logic [42:0] got_v, want_v;

    initial begin
        for (int i = 0; i < NI; i++) begin
            done_cnt[i] = 0;
            last_lat[i] = -1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                got_v  = dut_vec(i);
                want_v = exp_vec(i);
                nvec = nvec + 1;
                if (got_v !== want_v) begin
                    nerr = nerr + 1;
                    $display("FAIL outputs[%0d] cyc=%0d got=%h want=%h", i, cyc, got_v, want_v);
                end
                if (done_w[i]) begin
                    done_cnt[i] = done_cnt[i] + 1;
                    last_lat[i] = cyc - acc[i];
                end
            end
            nvec = nvec + 1;
            if (!$onehot0(btn_w[1]) || (btn_w[1] != 4'd0 && !mode_w[1]) ||
                (btn_w[1] != 4'd0 && prev_b1 != 4'd0 && btn_w[1] != prev_b1)) begin
                nerr = nerr + 1;
                $display("FAIL invariant cyc=%0d buttons=%b prev=%b mode=%b", cyc, btn_w[1], prev_b1, mode_w[1]);
            end
            prev_b1 = btn_w[1];
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        nvec = nvec + 1;
        if (got !== want) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic cast_votes(input int n0, input int n1, input int n2, input int n3);
        int n [4];
        n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < n[k]; j++) begin
                vote_btn = 4'(1 << k);
                @(negedge clk);
                vote_btn = 4'd0;
                @(negedge clk);
            end
        end
    endtask

    task automatic clear_votes();
        vm_clr = 1'b1;
        @(negedge clk);
        vm_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (done_w[0]) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_scan();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] snap;
    int d0;

    initial begin
        rst = 1'b1; start = 1'b0; vm_clr = 1'b1; vote_btn = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0; vm_clr = 1'b0;
        chk("reset_ctrl", 64'({mode_w[0], btn_w[0], busy_w[0], done_w[0], rv_w[0], win_w[0], tie_w[0]}), 64'd0);
        chk("reset_counts", 64'(counts_of(0)), 64'd0);
        @(negedge clk);

        cast_votes(2, 1, 1, 0);
        run_scan();
        chk("s1_counts", 64'(counts_of(0)), 64'h02010100);
        chk("s1_win_tie", 64'({win_w[0], tie_w[0]}), 64'd0);
        chk("s1_latency", 64'(last_lat[0]), 64'd81);
        chk("s1_short_latency", 64'(last_lat[1]), 64'd13);
        chk("s1_short_counts", 64'(counts_of(1)), 64'h02010100);

        clear_votes();
        cast_votes(3, 3, 0, 1);
        run_scan();
        chk("s2_counts", 64'(counts_of(0)), 64'h03030001);
        chk("s2_win_tie", 64'({win_w[0], tie_w[0]}), 64'd1);

        clear_votes();
        run_scan();
        chk("s3_counts", 64'(counts_of(0)), 64'd0);
        chk("s3_win_tie_valid", 64'({win_w[0], tie_w[0], rv_w[0]}), 64'b011);

        d0 = done_cnt[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("s4_midscan_busy", 64'(busy_w[0]), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("s4_single_done", 64'(done_cnt[0] - d0), 64'd1);
        chk("s4_no_requeue", 64'(busy_w[0]), 64'd0);

        start = 1'b1;
        wait_done();
        @(negedge clk);
        chk("s5_idle_after_done", 64'(busy_w[0]), 64'd0);
        @(negedge clk);
        chk("s5_retrigger", 64'({busy_w[0], mode_w[0]}), 64'b11);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        clear_votes();
        cast_votes(1, 2, 0, 0);
        snap = {tally[0][0], tally[0][1], tally[0][2], tally[0][3]};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        chk("s6_pressing", 64'({mode_w[0], btn_w[0]}), 64'b10010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s6_reset_ctrl", 64'({mode_w[0], btn_w[0], busy_w[0], done_w[0], rv_w[0]}), 64'd0);
        chk("s6_reset_counts", 64'(counts_of(0)), 64'd0);
        repeat (3) @(negedge clk);
        chk("s6_tally_kept", 64'({tally[0][0], tally[0][1], tally[0][2], tally[0][3]}), 64'(snap));
        chk("s6_tally_value", 64'(snap), 64'h01020000);
        run_scan();
        chk("s6_rescan_counts", 64'(counts_of(0)), 64'h01020000);
        chk("s6_rescan_win_tie", 64'({win_w[0], tie_w[0]}), 64'b010);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
